// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with wrap or saturate at the boundaries, synchronous load,
// a one-cycle wrap pulse, a sticky boundary-event flag and a combinational terminal count.
module mod_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : gen_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    // A boundary event below overrides this clear, so set wins over clr_ovf.
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          if (!sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          if (!sat) begin
            count_d = MaxVal;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign tc    = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed scenarios plus random cycles, all checked against
// an integer-arithmetic reference model.
module tb_mod_updown_counter;

  localparam int unsigned W = 4;
  localparam int          M = 10;

  logic         clk = 1'b0;
  logic         rst, en, up, sat, load, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap, tc, ovf;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_count;
  bit m_wrap;
  bit m_ovf;

  mod_updown_counter #(
    .WIDTH   (W),
    .MODULUS (M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .wrap     (wrap),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check tc, advance model and DUT, check registered outputs.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input bit s,
                     input bit c, input int lv, input string tag);
    int  nxt;
    bit  m_tc;
    rst      = r;
    load     = l;
    en       = e;
    up       = u;
    sat      = s;
    clr_ovf  = c;
    load_val = W'(lv);
    #1;
    m_tc = e && ((u && m_count == M - 1) || (!u && m_count == 0));
    check({tag, "_tc"}, 32'(tc), 32'(m_tc));
    if (r) begin
      m_count = 0;
      m_wrap  = 0;
      m_ovf   = 0;
    end else begin
      m_wrap = 0;
      if (c) m_ovf = 0;
      if (l) begin
        m_count = (lv < M) ? lv : M - 1;
      end else if (e) begin
        nxt = m_count + (u ? 1 : -1);
        if (nxt < 0 || nxt >= M) begin
          m_ovf = 1;
          if (!s) begin
            m_count = (nxt + M) % M;
            m_wrap  = 1;
          end
        end else begin
          m_count = nxt;
        end
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  initial begin
    int exp32[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp33[5]  = '{2, 1, 0, 9, 8};
    int wrp33[5]  = '{0, 0, 0, 1, 0};

    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; sat = 1'b0; clr_ovf = 1'b0;
    load_val = '0;
    m_count = 0; m_wrap = 0; m_ovf = 0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then count up through a wrap
    cyc(1, 0, 0, 0, 0, 0, 0, "rst");
    cyc(1, 0, 0, 0, 0, 0, 0, "rst");
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1, 0, 0, 0, "up");
      check("up_seq", 32'(count), 32'(exp32[i]));
      if (i == 9) check("up_wrap", 32'(wrap), 32'd1);
    end
    check("up_ovf_sticky", 32'(ovf), 32'd1);

    // Load 3 and count down through a wrap
    cyc(0, 1, 0, 0, 0, 0, 3, "ld3");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, "dn");
      check("dn_seq", 32'(count), 32'(exp33[i]));
      check("dn_wrap", 32'(wrap), 32'(wrp33[i]));
    end

    // Saturating up from 8; ovf cleared on the load so its setting is visible
    cyc(0, 1, 0, 1, 1, 1, 8, "ld8");
    check("sat_ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 0, 0, "sat");
      check("sat_hold", 32'(count), 32'd9);
      check("sat_nowrap", 32'(wrap), 32'd0);
      check("sat_ovf", 32'(ovf), (i == 0) ? 32'd0 : 32'd1);
    end
    cyc(0, 0, 0, 1, 1, 1, 0, "clr");
    check("clr_ovf", 32'(ovf), 32'd0);

    // Load clamping and load priority over en
    cyc(0, 1, 0, 0, 0, 0, 15, "clamp");
    check("clamp_count", 32'(count), 32'd9);
    cyc(0, 1, 1, 1, 0, 0, 2, "ld_en");
    check("ld_en_count", 32'(count), 32'd2);

    // Wrap and clr_ovf in the same cycle: set wins
    cyc(0, 1, 0, 0, 0, 0, 9, "ld9");
    cyc(0, 0, 1, 1, 0, 1, 0, "setwin");
    check("setwin_count", 32'(count), 32'd0);
    check("setwin_wrap", 32'(wrap), 32'd1);
    check("setwin_ovf", 32'(ovf), 32'd1);

    // Reset overrides load and en, mid-count and on a wrap cycle
    cyc(0, 1, 0, 0, 0, 0, 5, "ld5");
    cyc(1, 1, 1, 1, 0, 0, 7, "rst_mid");
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 9, "ld9b");
    cyc(1, 0, 1, 1, 0, 0, 0, "rst_wrap");
    check("rst_wrap_wrap", 32'(wrap), 32'd0);

    // Random cycles against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(31) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
          1'($urandom), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          int'($urandom_range(15)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
